uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync.sv | 30 +++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART constants: FSM encoding and default tick counts. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int c_DATA_BITS = 9;
    localparam int c_SP_TICKS  = 16;
    localparam int c_ST_TICKS  = 8;
    localparam int c_DT_TICKS  = 16;

    typedef logic [1:0] uart_state_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    function automatic int uart_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_sync                                                    |
// | Description : Two-flop synchronizer for the idle-high serial line.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_sync (
    input  logic clk,
    input  logic Reset_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : Oversampling UART receiver with even-parity and stop checks. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
#(
    parameter int Data_bits = c_DATA_BITS,
    parameter int Sp_ticks  = c_SP_TICKS,
    parameter int St_ticks  = c_ST_TICKS,
    parameter int Dt_ticks  = c_DT_TICKS
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    input  logic                 rx,
    input  logic                 s_ticks,
    output logic [Data_bits-2:0] data_out,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int c_W         = Data_bits - 1;
    localparam int c_START_MID = St_ticks / 2 - 1;
    localparam int c_FIRST     = St_ticks / 2 + Dt_ticks / 2 - 1;
    localparam int c_DT_LAST   = Dt_ticks - 1;
    localparam int c_STOP_MID  = Dt_ticks / 2 + Sp_ticks / 2 - 1;
    localparam int c_MAX_CNT   = uart_max(uart_max(c_START_MID, c_FIRST),
                                          uart_max(c_DT_LAST, c_STOP_MID));
    localparam int c_CW        = $clog2(c_MAX_CNT + 1);
    localparam int c_BW        = $clog2(Data_bits + 1);

    localparam logic [c_CW-1:0] c_CNT_START_MID = c_CW'(c_START_MID);
    localparam logic [c_CW-1:0] c_CNT_FIRST     = c_CW'(c_FIRST);
    localparam logic [c_CW-1:0] c_CNT_DT_LAST   = c_CW'(c_DT_LAST);
    localparam logic [c_CW-1:0] c_CNT_STOP_MID  = c_CW'(c_STOP_MID);
    localparam logic [c_BW-1:0] c_BIT_PAR       = c_BW'(Data_bits - 1);

    logic              rx_s;
    uart_state_t       state_q,     state_d;
    logic [c_CW-1:0]   cnt_q,       cnt_d;
    logic [c_BW-1:0]   bit_q,       bit_d;
    logic [c_W-1:0]    shreg_q,     shreg_d;
    logic              xor_q,       xor_d;
    logic              perr_pend_q, perr_pend_d;
    logic              rx_prev_q;
    logic [c_W-1:0]    data_q,      data_d;
    logic              done_q,      done_d;
    logic              perr_q,      perr_d;
    logic              ferr_q,      ferr_d;
    logic [c_CW-1:0]   w_data_target;
    logic [c_W:0]      w_shift;

    uart_sync u_sync (
        .clk     (clk),
        .Reset_n (Reset_n),
        .i_d     (rx),
        .o_q     (rx_s)
    );

    // First data sample is offset by half a start bit; the rest are a full bit apart.
    assign w_data_target = (bit_q == '0) ? c_CNT_FIRST : c_CNT_DT_LAST;
    assign w_shift       = {rx_s, shreg_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        xor_d       = xor_q;
        perr_pend_d = perr_pend_q;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        case (state_q)
            c_ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = c_ST_START;
                end
            end
            c_ST_START: begin
                if (s_ticks) begin
                    if (cnt_q == c_CNT_START_MID) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = c_ST_IDLE;
                        end else begin
                            bit_d   = '0;
                            xor_d   = 1'b0;
                            state_d = c_ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            c_ST_DATA: begin
                if (s_ticks) begin
                    if (cnt_q == w_data_target) begin
                        cnt_d = '0;
                        if (bit_q == c_BIT_PAR) begin
                            perr_pend_d = rx_s ^ xor_q;
                            state_d     = c_ST_STOP;
                        end else begin
                            shreg_d = w_shift[c_W:1];
                            xor_d   = xor_q ^ rx_s;
                            bit_d   = bit_q + c_BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            c_ST_STOP: begin
                if (s_ticks) begin
                    if (cnt_q == c_CNT_STOP_MID) begin
                        cnt_d   = '0;
                        data_d  = shreg_q;
                        perr_d  = perr_pend_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = c_ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            xor_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            rx_prev_q   <= 1'b1;
            data_q      <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            xor_q       <= xor_d;
            perr_pend_q <= perr_pend_d;
            rx_prev_q   <= rx_s;
            data_q      <= data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out     = data_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;

endmodule
`default_nettype wire
